// File: rtl/vpu_dcache_arb.sv
// Arbiter merging the scalar core data port and the vector LSU port onto one D$ port.
// Optional macro VPU_DCACHE_ARB_VPU_PRIORITY_EN: VPU wins every tie instead of round-robin.
module vpu_dcache_arb (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_request_i,
    input  logic [3:0]  cpu_write_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_in_i,
    output logic        cpu_wait_o,
    output logic [31:0] cpu_out_o,
    input  logic        vpu_request_i,
    input  logic [3:0]  vpu_write_i,
    input  logic [31:0] vpu_addr_i,
    input  logic [31:0] vpu_in_i,
    output logic        vpu_wait_o,
    output logic [31:0] vpu_out_o,
    output logic        dcache_request_o,
    output logic [3:0]  dcache_write_o,
    output logic [31:0] dcache_addr_o,
    output logic [31:0] dcache_in_o,
    input  logic        dcache_wait_i,
    input  logic [31:0] dcache_out_i
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VPU  = 2'd2
    } own_e;

    own_e        own_q, own_d;
    logic        cpu_pend_q, cpu_pend_d;
    logic        vpu_pend_q, vpu_pend_d;
    logic [3:0]  cpu_pwrite_q, vpu_pwrite_q;
    logic [31:0] cpu_paddr_q, vpu_paddr_q;
    logic [31:0] cpu_pin_q, vpu_pin_q;
    logic        cpu_cap, vpu_cap;

    logic        can_issue;
    logic        cpu_cand, vpu_cand;
    logic        grant_cpu, grant_vpu;
    logic [3:0]  cpu_c_write, vpu_c_write;
    logic [31:0] cpu_c_addr, vpu_c_addr;
    logic [31:0] cpu_c_in, vpu_c_in;

`ifndef VPU_DCACHE_ARB_VPU_PRIORITY_EN
    // last_q = 1 means the VPU was granted most recently
    logic        last_q, last_d;
`endif

    // A buffered request always takes precedence over the live one on the same side
    always_comb begin
        cpu_cand    = cpu_pend_q | cpu_request_i;
        vpu_cand    = vpu_pend_q | vpu_request_i;
        cpu_c_write = cpu_pend_q ? cpu_pwrite_q : cpu_write_i;
        cpu_c_addr  = cpu_pend_q ? cpu_paddr_q  : cpu_addr_i;
        cpu_c_in    = cpu_pend_q ? cpu_pin_q    : cpu_in_i;
        vpu_c_write = vpu_pend_q ? vpu_pwrite_q : vpu_write_i;
        vpu_c_addr  = vpu_pend_q ? vpu_paddr_q  : vpu_addr_i;
        vpu_c_in    = vpu_pend_q ? vpu_pin_q    : vpu_in_i;
        can_issue   = (own_q == OWN_IDLE) | !dcache_wait_i;
    end

    always_comb begin
        grant_cpu = 1'b0;
        grant_vpu = 1'b0;
        if (can_issue && !rst_i) begin
            if (cpu_cand && vpu_cand) begin
`ifdef VPU_DCACHE_ARB_VPU_PRIORITY_EN
                grant_vpu = 1'b1;
`else
                grant_cpu = last_q;
                grant_vpu = !last_q;
`endif
            end else if (cpu_cand) begin
                grant_cpu = 1'b1;
            end else if (vpu_cand) begin
                grant_vpu = 1'b1;
            end
        end
    end

    always_comb begin
        dcache_request_o = grant_cpu | grant_vpu;
        dcache_write_o   = 4'd0;
        dcache_addr_o    = 32'd0;
        dcache_in_o      = 32'd0;
        if (grant_cpu) begin
            dcache_write_o = cpu_c_write;
            dcache_addr_o  = cpu_c_addr;
            dcache_in_o    = cpu_c_in;
        end else if (grant_vpu) begin
            dcache_write_o = vpu_c_write;
            dcache_addr_o  = vpu_c_addr;
            dcache_in_o    = vpu_c_in;
        end
    end

    // A live request arriving while its side is already pending is dropped
    always_comb begin
        own_d      = own_q;
        cpu_pend_d = cpu_pend_q;
        vpu_pend_d = vpu_pend_q;
        cpu_cap    = cpu_request_i & !cpu_pend_q & !grant_cpu;
        vpu_cap    = vpu_request_i & !vpu_pend_q & !grant_vpu;
`ifndef VPU_DCACHE_ARB_VPU_PRIORITY_EN
        last_d     = last_q;
        if (grant_cpu) last_d = 1'b0;
        if (grant_vpu) last_d = 1'b1;
`endif
        if (can_issue) begin
            if (grant_cpu)      own_d = OWN_CPU;
            else if (grant_vpu) own_d = OWN_VPU;
            else                own_d = OWN_IDLE;
        end
        if (grant_cpu) cpu_pend_d = 1'b0;
        if (grant_vpu) vpu_pend_d = 1'b0;
        if (cpu_cap)   cpu_pend_d = 1'b1;
        if (vpu_cap)   vpu_pend_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            own_q      <= OWN_IDLE;
            cpu_pend_q <= 1'b0;
            vpu_pend_q <= 1'b0;
`ifndef VPU_DCACHE_ARB_VPU_PRIORITY_EN
            last_q     <= 1'b1;
`endif
        end else begin
            own_q      <= own_d;
            cpu_pend_q <= cpu_pend_d;
            vpu_pend_q <= vpu_pend_d;
`ifndef VPU_DCACHE_ARB_VPU_PRIORITY_EN
            last_q     <= last_d;
`endif
        end
    end

    // Buffer payloads are qualified by the pend flags, so they need no reset
    always_ff @(posedge clk_i) begin
        if (cpu_cap) begin
            cpu_pwrite_q <= cpu_write_i;
            cpu_paddr_q  <= cpu_addr_i;
            cpu_pin_q    <= cpu_in_i;
        end
        if (vpu_cap) begin
            vpu_pwrite_q <= vpu_write_i;
            vpu_paddr_q  <= vpu_addr_i;
            vpu_pin_q    <= vpu_in_i;
        end
    end

    always_comb begin
        cpu_wait_o = cpu_pend_q | ((own_q == OWN_CPU) & dcache_wait_i);
        vpu_wait_o = vpu_pend_q | ((own_q == OWN_VPU) & dcache_wait_i);
        cpu_out_o  = (own_q == OWN_CPU) ? dcache_out_i : 32'd0;
        vpu_out_o  = (own_q == OWN_VPU) ? dcache_out_i : 32'd0;
    end

endmodule

// File: doc/vpu_dcache_arb.md
# vpu_dcache_arb

Two-port arbiter between the scalar core's data-memory port and the vector LSU's D$ port, merging both onto the single D$ request/response interface. It accepts one-cycle request pulses from either side, holds a request that arrives while the D$ is busy, grants round-robin, and returns each response only to the side that owns it. It sits directly downstream of the vector LSU, between the LSU and the D$.

## Interface
- No parameters; address and data widths are fixed at 32 bits, the byte-write mask at 4 bits.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cpu_request_i` in 1: scalar core request pulse.
- `cpu_write_i` in 4: byte-write mask; 0 means read.
- `cpu_addr_i` in 32: scalar core address.
- `cpu_in_i` in 32: scalar core store data.
- `cpu_wait_o` out 1: scalar core side busy.
- `cpu_out_o` out 32: read data to the scalar core.
- `vpu_request_i` in 1: vector LSU request pulse.
- `vpu_write_i` in 4: vector LSU byte-write mask; 0 means read.
- `vpu_addr_i` in 32: vector LSU address.
- `vpu_in_i` in 32: vector LSU store data.
- `vpu_wait_o` out 1: vector LSU side busy.
- `vpu_out_o` out 32: read data to the vector LSU.
- `dcache_request_o` out 1: merged request to the D$.
- `dcache_write_o` out 4: merged byte-write mask.
- `dcache_addr_o` out 32: merged address.
- `dcache_in_o` out 32: merged store data.
- `dcache_wait_i` in 1: D$ busy.
- `dcache_out_i` in 32: D$ read data.

## Operation
- Protocol (both sides): a request is a one-cycle pulse. It is complete in the first cycle after its issue cycle with wait = 0. Read data is valid in that completion cycle. A requester may issue its next request in that same completion cycle. Writes complete the same way; their read data is ignored.
- State `own_q`: IDLE / OWN_CPU / OWN_VPU. This is the owner of the single outstanding D$ request.
- `can_issue = (own_q==IDLE) | (own_q!=IDLE & !dcache_wait_i)`.
- Per-requester one-entry pending buffer: `pend_q`, write, addr, in.
- Candidate per side: the buffered request if `pend_q`, otherwise the live request if `request_i`.
- Grant:
  - If `can_issue` and at least one candidate exists, grant one candidate.
  - The granted candidate drives `dcache_*_o` combinationally in the same cycle; `dcache_request_o` = 1.
  - `own_q` ← granted side.
  - `last_q` ← granted side.
  - If the granted candidate was buffered, its `pend_q` ← 0.
- Tie (both sides have a candidate): grant the side that is not `last_q`.
- Any live request that is not granted is captured into its side's buffer.
- If `can_issue` and there is no candidate: `own_q` ← IDLE.
- Outputs:
  - `x_wait_o = pend_q[x] | (own_q==x & dcache_wait_i)`.
  - `x_out_o = (own_q==x) ? dcache_out_i : 0`.
- A side that is neither pending nor owner sees wait = 0 and out = 0.
- Protocol violation: a live request while that side's `pend_q` = 1 is dropped, and the buffered request is kept.
- Reset values:
  - `own_q` = IDLE, `last_q` = VPU (so the scalar core wins the first tie), `pend_q` = 0.
  - All outputs 0.
- Reset asserted mid-transaction: owner and buffers clear immediately; a D$ response in flight is discarded.

## Timing
- Uncontended request: issued to the D$ in the same cycle as the request (zero added latency). Response is returned in the D$ completion cycle.
- Back-to-back: a new request in a completion cycle issues in that cycle with no bubble.
- A buffered request issues in the owner's completion cycle at the earliest: one extra D$ round trip per losing request.
- At most one D$ request is outstanding at any time. There are at most two buffered requests, one per side.

## Configuration
- `VPU_DCACHE_ARB_VPU_PRIORITY_EN`
  - Defined: fixed priority on ties; the VPU always wins and `last_q` is unused.
  - Undefined: round-robin as described above.
- Either way a losing request is buffered, never dropped.

## Test plan
- Single CPU read to 0x100, D$ wait held 1 cycle then low with out = 0xDEADBEEF:
  - request issued to the D$ at T;
  - `cpu_wait_o` = 1 at T+1;
  - `cpu_out_o` = 0xDEADBEEF at T+2;
  - `vpu_out_o` = 0 throughout.
- Simultaneous CPU read 0x10 and VPU write 0x20 (mask 0xF) just after reset:
  - CPU issued first; VPU buffered with `vpu_wait_o` = 1;
  - VPU write issued in the CPU completion cycle.
  - With `VPU_DCACHE_ARB_VPU_PRIORITY_EN` defined, the order is reversed.
- VPU streaming reads to 0x0, 0x4, 0x8 (each reissued in its completion cycle), D$ zero-wait:
  - addresses appear on consecutive cycles;
  - each response is on `vpu_out_o` the next cycle.
- Repeated contention for 4 rounds:
  - grants alternate CPU, VPU, CPU, VPU (macro undefined).
- VPU request while the CPU owns the D$ and `dcache_wait_i` = 1 for 5 cycles:
  - VPU held in its buffer;
  - `vpu_wait_o` = 1 for 5 cycles;
  - VPU issued in the CPU completion cycle.
- Reset asserted while the VPU owns the D$ and the CPU is pending:
  - all outputs 0 immediately and both waits = 0;
  - after release, the first new request issues normally.
